// File: rtl/jump_control_block.sv
// jump_control_block
//   Branch/interrupt steering unit of the 8-bit processor.
//
//   This block decodes the jump-class instruction that is in the execute
//   stage. It checks branch conditions against the ALU flags and detects
//   rising edges on the interrupt request. It then drives the PC mux select
//   and the jump target. One return address is held, so interrupts are
//   single-level and are not nested.
//
//   Ports:
//     clk              system clock, rising edge
//     reset            synchronous active-low reset
//     ins[19:0]        current instruction; opcode ins[19:15], target ins[7:0]
//     interrupt        interrupt request (level input, rising-edge accepted)
//     current_address  PC of the current instruction
//     flag_ex[3:0]     ALU flags {V,N,Z,C}
//     pc_mux_sel       1 = load PC from jmp_loc, 0 = sequential PC
//     jmp_loc[7:0]     jump target, 8'h00 whenever pc_mux_sel is 0
//
//   Optional build macro JCB_FLAG_RESTORE_EN:
//     When defined, the flags present at interrupt entry are saved.
//     A conditional jump in the cycle right after RET then tests those
//     saved flags instead of the live ALU flags.

module jump_control_block #(
    parameter logic [7:0] INT_VECTOR = 8'hF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] ins,
    input  logic        interrupt,
    input  logic [7:0]  current_address,
    input  logic [3:0]  flag_ex,
    output logic        pc_mux_sel,
    output logic [7:0]  jmp_loc
);

    localparam logic [4:0] OP_JMP = 5'b11000;
    localparam logic [4:0] OP_JC  = 5'b11100;
    localparam logic [4:0] OP_JNC = 5'b11110;
    localparam logic [4:0] OP_JZ  = 5'b11101;
    localparam logic [4:0] OP_JNZ = 5'b11111;
    localparam logic [4:0] OP_RET = 5'b10000;

    logic       int_prev;
    logic       in_isr;
    logic [7:0] ret_addr;
    logic [3:0] eff_flags;
    logic       int_take;
    logic       is_ret;
    logic       sel_d;
    logic [7:0] loc_d;
    logic [4:0] opcode;

    // The middle instruction bits carry no meaning for jump-class decode.
    logic unused_ins_bits;
    assign unused_ins_bits = ^ins[14:8];

    assign opcode   = ins[19:15];
    assign int_take = interrupt & ~int_prev & ~in_isr;

`ifdef JCB_FLAG_RESTORE_EN
    logic [3:0] saved_flags;
    logic       restore_pend;
    assign eff_flags = restore_pend ? saved_flags : flag_ex;
`else
    assign eff_flags = flag_ex;
`endif

    always_comb begin
        sel_d  = 1'b0;
        loc_d  = 8'h00;
        is_ret = 1'b0;
        if (int_take) begin
            sel_d = 1'b1;
            loc_d = INT_VECTOR;
        end else begin
            case (opcode)
                OP_JMP: begin
                    sel_d = 1'b1;
                    loc_d = ins[7:0];
                end
                OP_JC: begin
                    sel_d = eff_flags[0];
                    loc_d = eff_flags[0] ? ins[7:0] : 8'h00;
                end
                OP_JNC: begin
                    sel_d = ~eff_flags[0];
                    loc_d = eff_flags[0] ? 8'h00 : ins[7:0];
                end
                OP_JZ: begin
                    sel_d = eff_flags[1];
                    loc_d = eff_flags[1] ? ins[7:0] : 8'h00;
                end
                OP_JNZ: begin
                    sel_d = ~eff_flags[1];
                    loc_d = eff_flags[1] ? 8'h00 : ins[7:0];
                end
                OP_RET: begin
                    sel_d  = 1'b1;
                    loc_d  = ret_addr;
                    is_ret = 1'b1;
                end
                default: begin
                    sel_d = 1'b0;
                    loc_d = 8'h00;
                end
            endcase
        end
    end

    // Outputs are held quiet while the core is in reset.
    assign pc_mux_sel = reset & sel_d;
    assign jmp_loc    = reset ? loc_d : 8'h00;

    always_ff @(posedge clk) begin
        if (!reset) begin
            int_prev <= 1'b0;
            in_isr   <= 1'b0;
            ret_addr <= 8'h00;
        end else begin
            int_prev <= interrupt;
            if (int_take) begin
                // The 8-bit add wraps naturally, so 8'hFF returns to 8'h00.
                ret_addr <= current_address + 8'd1;
                in_isr   <= 1'b1;
            end else if (is_ret) begin
                in_isr <= 1'b0;
            end
        end
    end

`ifdef JCB_FLAG_RESTORE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            saved_flags  <= 4'h0;
            restore_pend <= 1'b0;
        end else begin
            if (int_take) begin
                saved_flags <= flag_ex;
            end
            restore_pend <= is_ret;
        end
    end
`endif

endmodule

// File: tb/tb_jump_control_block.sv
module tb_jump_control_block;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] ins;
    logic        interrupt;
    logic [7:0]  current_address;
    logic [3:0]  flag_ex;
    logic        pc_mux_sel;
    logic [7:0]  jmp_loc;

    jump_control_block #(.INT_VECTOR(8'hF0)) dut (
        .clk             (clk),
        .reset           (reset),
        .ins             (ins),
        .interrupt       (interrupt),
        .current_address (current_address),
        .flag_ex         (flag_ex),
        .pc_mux_sel      (pc_mux_sel),
        .jmp_loc         (jmp_loc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [7:0] loc;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_applied = 0;
    int   n_miscompare = 0;
    bit   stim_done = 1'b0;

`ifdef JCB_FLAG_RESTORE_EN
    localparam logic       JZ_AFTER_RET_SEL = 1'b1;
    localparam logic [7:0] JZ_AFTER_RET_LOC = 8'h10;
`else
    localparam logic       JZ_AFTER_RET_SEL = 1'b0;
    localparam logic [7:0] JZ_AFTER_RET_LOC = 8'h00;
`endif

    // Drive one vector just after the rising edge and queue its expectation.
    task automatic vec(input logic r, input logic [19:0] i, input logic irq,
                       input logic [7:0] a, input logic [3:0] f,
                       input logic es, input logic [7:0] el, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = r;
        ins             = i;
        interrupt       = irq;
        current_address = a;
        flag_ex         = f;
        e.sel  = es;
        e.loc  = el;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: the outputs are combinational, so every cycle presents one
    // result. They are sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_applied++;
            if (pc_mux_sel !== e.sel || jmp_loc !== e.loc) begin
                n_miscompare++;
                $display("FAIL %s: got sel=%0b loc=%02h, want sel=%0b loc=%02h",
                         e.name, pc_mux_sel, jmp_loc, e.sel, e.loc);
            end
        end
    end

    initial begin
        reset = 1'b0; ins = '0; interrupt = 1'b0; current_address = '0; flag_ex = '0;

        vec(0, 20'h00000, 0, 8'h00, 4'h8, 0, 8'h00, "reset_a");
        vec(0, 20'hC0055, 0, 8'h00, 4'h8, 0, 8'h00, "reset_jmp_forced");
        vec(1, 20'h00000, 0, 8'h00, 4'h8, 0, 8'h00, "idle");
        vec(1, 20'h00000, 1, 8'h01, 4'h0, 1, 8'hF0, "int_accept");
        vec(1, 20'h00000, 1, 8'h02, 4'h0, 0, 8'h00, "int_held");
        vec(1, 20'h00008, 0, 8'h03, 4'h0, 0, 8'h00, "nonjump");
        vec(1, 20'hC0008, 0, 8'h04, 4'h0, 1, 8'h08, "jmp");
        vec(1, 20'h80008, 0, 8'h05, 4'h0, 1, 8'h02, "ret");
        vec(1, 20'h00000, 1, 8'h04, 4'h0, 1, 8'hF0, "int_after_ret");
        vec(1, 20'h80000, 0, 8'h06, 4'h0, 1, 8'h05, "ret2");
        vec(1, 20'h00000, 0, 8'h07, 4'h0, 0, 8'h00, "nop");
        vec(1, 20'hF8008, 0, 8'h08, 4'h8, 1, 8'h08, "jnz_taken");
        vec(1, 20'hF8008, 0, 8'h09, 4'hA, 0, 8'h00, "jnz_not");
        vec(1, 20'hE0010, 0, 8'h0A, 4'h1, 1, 8'h10, "jc_taken");
        vec(1, 20'hE0010, 0, 8'h0B, 4'h2, 0, 8'h00, "jc_not");
        vec(1, 20'hF0010, 0, 8'h0C, 4'h1, 0, 8'h00, "jnc_not");
        vec(1, 20'hF0020, 0, 8'h0D, 4'h0, 1, 8'h20, "jnc_taken");
        vec(1, 20'hE8030, 0, 8'h0E, 4'h2, 1, 8'h30, "jz_taken");
        vec(1, 20'hE8030, 0, 8'h0F, 4'h0, 0, 8'h00, "jz_not");
        vec(1, 20'h00000, 1, 8'hFF, 4'h2, 1, 8'hF0, "int_wrap");
        vec(1, 20'h00000, 0, 8'h00, 4'h0, 0, 8'h00, "isr_body");
        vec(1, 20'h80000, 0, 8'h01, 4'h0, 1, 8'h00, "ret_wrap");
        vec(1, 20'hE8010, 0, 8'h00, 4'h0, JZ_AFTER_RET_SEL, JZ_AFTER_RET_LOC, "jz_after_ret");
        vec(1, 20'hE8010, 0, 8'h01, 4'h0, 0, 8'h00, "jz_live_flags");
        vec(1, 20'hC0033, 1, 8'h10, 4'h0, 1, 8'hF0, "int_over_jmp");
        vec(1, 20'hC0033, 1, 8'hF0, 4'h0, 1, 8'h33, "jmp_in_isr");
        vec(0, 20'h80000, 1, 8'hF1, 4'h0, 0, 8'h00, "reset_mid_isr");
        vec(1, 20'h80000, 0, 8'h00, 4'h0, 1, 8'h00, "ret_after_reset");
        vec(1, 20'h00000, 1, 8'h20, 4'h0, 1, 8'hF0, "int_after_reset");

        stim_done = 1'b1;
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_miscompare++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

    initial begin
        #20000;
        if (!stim_done) begin
            $display("FAIL timeout: stimulus did not complete, want completion");
            $fatal(1, "timeout");
        end
    end

endmodule
